// File: rtl/pipelined_barrel_shifter_if.sv
// Handshake bundle for the pipelined barrel shifter.
// The issue side is in_*; the writeback side is out_*.
// The slave modport is the shifter's view; the master modport is the surrounding datapath's view.
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_op;
    logic [SHAMT_W-1:0] in_shamt;
    logic [WIDTH-1:0]   in_operand;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_result;
    logic [TAG_W-1:0]   out_tag;

    modport slave (
        input  in_valid, in_op, in_shamt, in_operand, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );

    modport master (
        output in_valid, in_op, in_shamt, in_operand, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SRL, SRA, SLL and ROR on a WIDTH-bit operand.
// The shift levels run from the largest amount (WIDTH/2) down to 1.
// A register stage follows every LEVELS_PER_STAGE levels.
// SLL reverses the operand's bits on entry, runs down the SRL path, and is reversed back in the last stage.
// The whole pipe moves or holds on one global advance, so bubbles are kept, not collapsed.
module pipelined_barrel_shifter #(
    parameter int WIDTH            = 32,
    parameter int LEVELS_PER_STAGE = 1,
    parameter int TAG_W            = 5
) (
    input logic                       clock,
    input logic                       reset,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int LATENCY = (SHAMT_W + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_SLL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    logic w_advance;

    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = d[WIDTH-1-i];
        end
        return r;
    endfunction

    // One right-shift level by a fixed amount.
    // The vacated MSBs take the wrapped-around bits (ROR), the carried sign (SRA) or zero (SRL, and SLL after reversal).
    function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                     input logic [1:0]       op,
                                                     input logic             sign,
                                                     input int               amt);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            if (i + amt < WIDTH) begin
                r[i] = d[i + amt];
            end else if (op == OP_ROR) begin
                r[i] = d[i + amt - WIDTH];
            end else if (op == OP_SRA) begin
                r[i] = sign;
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    // Output register full and not taken -> the whole pipe holds.
    assign w_advance    = !g_stage[LATENCY-1].r_vld || bus.out_ready;
    assign bus.in_ready = w_advance;

    for (genvar s = 0; s < LATENCY; s++) begin : g_stage
        localparam int J_LO = s * LEVELS_PER_STAGE;
        localparam int J_HI = ((s + 1) * LEVELS_PER_STAGE < SHAMT_W) ?
                              (s + 1) * LEVELS_PER_STAGE : SHAMT_W;

        logic               w_vld;
        logic [1:0]         w_op;
        logic               w_sign;
        logic [SHAMT_W-1:0] w_shamt;
        logic [WIDTH-1:0]   w_src;
        logic [WIDTH-1:0]   w_dst;
        logic [TAG_W-1:0]   w_tag;
        logic               w_unused_fields;

        logic               r_vld;
        logic [1:0]         r_op;
        logic               r_sign;
        logic [SHAMT_W-1:0] r_shamt;
        logic [WIDTH-1:0]   r_data;
        logic [TAG_W-1:0]   r_tag;

        if (s == 0) begin : g_src_in
            assign w_vld   = bus.in_valid;
            assign w_op    = bus.in_op;
            assign w_sign  = bus.in_operand[WIDTH-1];
            assign w_shamt = bus.in_shamt;
            assign w_src   = (bus.in_op == OP_SLL) ? bit_reverse(bus.in_operand) : bus.in_operand;
            assign w_tag   = bus.in_tag;
        end else begin : g_src_prev
            assign w_vld   = g_stage[s-1].r_vld;
            assign w_op    = g_stage[s-1].r_op;
            assign w_sign  = g_stage[s-1].r_sign;
            assign w_shamt = g_stage[s-1].r_shamt;
            assign w_src   = g_stage[s-1].r_data;
            assign w_tag   = g_stage[s-1].r_tag;
        end

        // Apply this stage's levels, largest amount first; the last stage undoes the SLL reversal.
        always_comb begin
            w_dst = w_src;
            for (int j = J_LO; j < J_HI; j++) begin
                if (w_shamt[SHAMT_W-1-j]) begin
                    w_dst = shift_level(w_dst, w_op, w_sign, 1 << (SHAMT_W - 1 - j));
                end
            end
            if ((s == LATENCY - 1) && (w_op == OP_SLL)) begin
                w_dst = bit_reverse(w_dst);
            end
        end

        // Stage register: loads on the global advance; a bubble loads as an all-zero beat so X never travels.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_vld   <= 1'b0;
                r_op    <= '0;
                r_sign  <= 1'b0;
                r_shamt <= '0;
                r_data  <= '0;
                r_tag   <= '0;
            end else if (w_advance) begin
                r_vld   <= w_vld;
                r_op    <= w_vld ? w_op    : '0;
                r_sign  <= w_vld ? w_sign  : 1'b0;
                r_shamt <= w_vld ? w_shamt : '0;
                r_data  <= w_vld ? w_dst   : '0;
                r_tag   <= w_vld ? w_tag   : '0;
            end
        end

        // The control fields are carried uniformly through every stage.
        // Some bits, such as consumed shamt bits and the last stage's op and sign, have no reader.
        assign w_unused_fields = ^{r_op, r_sign, r_shamt};
    end

    assign bus.out_valid  = g_stage[LATENCY-1].r_vld;
    assign bus.out_result = g_stage[LATENCY-1].r_data;
    assign bus.out_tag    = g_stage[LATENCY-1].r_tag;
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter in three configurations:
//   A: WIDTH=32, LEVELS_PER_STAGE=1 (latency 5)
//   B: WIDTH=32, LEVELS_PER_STAGE=5 (latency 1)
//   C: WIDTH=8,  LEVELS_PER_STAGE=1 (latency 3)
module tb_pipelined_barrel_shifter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    pipelined_barrel_shifter_if #(.WIDTH(32), .TAG_W(5)) ia ();
    pipelined_barrel_shifter_if #(.WIDTH(32), .TAG_W(5)) ib ();
    pipelined_barrel_shifter_if #(.WIDTH(8),  .TAG_W(5)) ic ();

    pipelined_barrel_shifter #(.WIDTH(32), .LEVELS_PER_STAGE(1), .TAG_W(5))
        u_a (.clock(clk), .reset(rst), .bus(ia));
    pipelined_barrel_shifter #(.WIDTH(32), .LEVELS_PER_STAGE(5), .TAG_W(5))
        u_b (.clock(clk), .reset(rst), .bus(ib));
    pipelined_barrel_shifter #(.WIDTH(8),  .LEVELS_PER_STAGE(1), .TAG_W(5))
        u_c (.clock(clk), .reset(rst), .bus(ic));

    task automatic drive(input int d, input logic v, input logic [1:0] op,
                         input logic [4:0] sh, input logic [31:0] x, input logic [4:0] tag);
        case (d)
            0: begin ia.in_valid = v; ia.in_op = op; ia.in_shamt = sh; ia.in_operand = x; ia.in_tag = tag; end
            1: begin ib.in_valid = v; ib.in_op = op; ib.in_shamt = sh; ib.in_operand = x; ib.in_tag = tag; end
            default: begin
                ic.in_valid = v; ic.in_op = op; ic.in_shamt = sh[2:0]; ic.in_operand = x[7:0]; ic.in_tag = tag;
            end
        endcase
    endtask

    task automatic drive_idle(input int d);
        drive(d, 1'b0, 2'bxx, 5'bxxxxx, 32'hxxxxxxxx, 5'bxxxxx);
    endtask

    task automatic set_ready(input int d, input logic r);
        case (d)
            0: ia.out_ready = r;
            1: ib.out_ready = r;
            default: ic.out_ready = r;
        endcase
    endtask

    function automatic logic get_ov(input int d);
        case (d)
            0: return ia.out_valid;
            1: return ib.out_valid;
            default: return ic.out_valid;
        endcase
    endfunction

    function automatic logic get_ir(input int d);
        case (d)
            0: return ia.in_ready;
            1: return ib.in_ready;
            default: return ic.in_ready;
        endcase
    endfunction

    function automatic logic [31:0] get_res(input int d);
        case (d)
            0: return ia.out_result;
            1: return ib.out_result;
            default: return {24'h0, ic.out_result};
        endcase
    endfunction

    function automatic logic [4:0] get_tag(input int d);
        case (d)
            0: return ia.out_tag;
            1: return ib.out_tag;
            default: return ic.out_tag;
        endcase
    endfunction

    function automatic logic [31:0] ref_model(input int w, input logic [1:0] op,
                                              input logic [4:0] sh, input logic [31:0] x);
        logic [31:0] r;
        logic [7:0]  b;
        logic [2:0]  s8;
        if (w == 32) begin
            case (op)
                2'b00:   r = x >> sh;
                2'b01:   r = $unsigned($signed(x) >>> sh);
                2'b10:   r = x << sh;
                default: r = (sh == 5'd0) ? x : ((x >> sh) | (x << (6'd32 - {1'b0, sh})));
            endcase
        end else begin
            b  = x[7:0];
            s8 = sh[2:0];
            case (op)
                2'b00:   r = {24'h0, b >> s8};
                2'b01:   r = {24'h0, $unsigned($signed(b) >>> s8)};
                2'b10:   r = {24'h0, b << s8};
                default: r = {24'h0, (s8 == 3'd0) ? b : ((b >> s8) | (b << (4'd8 - {1'b0, s8})))};
            endcase
        end
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #1;
        tests++;
        if (ia.out_valid !== 1'b0 || ib.out_valid !== 1'b0 || ic.out_valid !== 1'b0) begin
            failed++;
            $display("FAIL reset_out_valid: got a=%b b=%b c=%b, want 0", ia.out_valid, ib.out_valid, ic.out_valid);
        end
        tests++;
        if (ia.out_result !== 32'h0 || ia.out_tag !== 5'h0) begin
            failed++;
            $display("FAIL reset_out_data: got result=%h tag=%h, want 0", ia.out_result, ia.out_tag);
        end
        tests++;
        if (ia.in_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_in_ready: got %b, want 1", ia.in_ready);
        end
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One beat into an empty pipe.
    // Checks the acceptance, the number of edges until out_valid (counting the accepting edge), the result and the tag.
    task automatic run_one(input int d, input int lat, input logic [1:0] op, input logic [4:0] sh,
                           input logic [31:0] x, input logic [4:0] tag, input logic [31:0] expv,
                           input string nm);
        int n;
        set_ready(d, 1'b1);
        drive(d, 1'b1, op, sh, x, tag);
        #1;
        tests++;
        if (get_ir(d) !== 1'b1) begin
            failed++;
            $display("FAIL %s_in_ready: got %b, want 1", nm, get_ir(d));
        end
        @(posedge clk);
        #1;
        drive_idle(d);
        n = 1;
        while (get_ov(d) !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests++;
        if (n != lat) begin
            failed++;
            $display("FAIL %s_latency: got %0d edges, want %0d", nm, n, lat);
        end
        tests++;
        if (get_res(d) !== expv) begin
            failed++;
            $display("FAIL %s_result: got %h, want %h", nm, get_res(d), expv);
        end
        tests++;
        if (get_tag(d) !== tag) begin
            failed++;
            $display("FAIL %s_tag: got %h, want %h", nm, get_tag(d), tag);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ops_a();
        run_one(0, 5, 2'b00, 5'd31, 32'h80000000, 5'd1,  32'h00000001, "a_srl31");
        run_one(0, 5, 2'b01, 5'd4,  32'h80000000, 5'd2,  32'hF8000000, "a_sra_neg");
        run_one(0, 5, 2'b01, 5'd4,  32'h7FFFFFF0, 5'd3,  32'h07FFFFFF, "a_sra_pos");
        run_one(0, 5, 2'b01, 5'd31, 32'h80000000, 5'd4,  32'hFFFFFFFF, "a_sra31");
        run_one(0, 5, 2'b10, 5'd31, 32'h00000001, 5'd5,  32'h80000000, "a_sll31");
        run_one(0, 5, 2'b10, 5'd0,  32'hDEADBEEF, 5'd6,  32'hDEADBEEF, "a_sll0");
        run_one(0, 5, 2'b10, 5'd4,  32'h0000000F, 5'd7,  32'h000000F0, "a_sll4");
        run_one(0, 5, 2'b11, 5'd1,  32'h00000001, 5'd8,  32'h80000000, "a_ror1");
        run_one(0, 5, 2'b11, 5'd8,  32'h12345678, 5'd9,  32'h78123456, "a_ror8");
    endtask

    task automatic test_ops_b();
        run_one(1, 1, 2'b00, 5'd31, 32'h80000000, 5'd11, 32'h00000001, "b_srl31");
        run_one(1, 1, 2'b01, 5'd4,  32'h80000000, 5'd12, 32'hF8000000, "b_sra_neg");
        run_one(1, 1, 2'b01, 5'd4,  32'h7FFFFFF0, 5'd13, 32'h07FFFFFF, "b_sra_pos");
        run_one(1, 1, 2'b10, 5'd31, 32'h00000001, 5'd14, 32'h80000000, "b_sll31");
        run_one(1, 1, 2'b11, 5'd8,  32'h12345678, 5'd15, 32'h78123456, "b_ror8");
    endtask

    task automatic test_ops_c();
        run_one(2, 3, 2'b01, 5'd7, 32'h00000080, 5'd21, 32'h000000FF, "c_sra7");
        run_one(2, 3, 2'b00, 5'd7, 32'h00000080, 5'd22, 32'h00000001, "c_srl7");
        run_one(2, 3, 2'b10, 5'd7, 32'h00000001, 5'd23, 32'h00000080, "c_sll7");
        run_one(2, 3, 2'b11, 5'd4, 32'h00000012, 5'd24, 32'h00000021, "c_ror4");
        run_one(2, 3, 2'b10, 5'd0, 32'h000000B5, 5'd25, 32'h000000B5, "c_sll0");
    endtask

    // 8 beats at full rate, tags 0..7, with out_ready dropped for 3 cycles once 3 results have left.
    task automatic test_back_to_back(input int d, input int w);
        logic [1:0]  ops [8] = '{2'd1, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3, 2'd2, 2'd1};
        logic [4:0]  shs [8] = '{5'd5, 5'd13, 5'd7, 5'd31, 5'd0, 5'd27, 5'd1, 5'd16};
        logic [31:0] xs  [8] = '{32'h9ABCDEF0, 32'h13579BDF, 32'h0F0F0F0F, 32'hFFFFFFFF,
                                 32'h80000001, 32'hCAFEBABE, 32'h7FFFFFFF, 32'h87654321};
        logic [31:0] expv [8];
        logic [31:0] snap_res;
        logic [4:0]  snap_tag;
        int sent, got, cyc, stall_left;
        bit stall_started;
        for (int i = 0; i < 8; i++) expv[i] = ref_model(w, ops[i], shs[i], xs[i]);
        sent = 0; got = 0; cyc = 0; stall_left = 0; stall_started = 0;
        snap_res = '0; snap_tag = '0;
        while (got < 8 && cyc < 200) begin
            if (sent < 8) drive(d, 1'b1, ops[sent], shs[sent], xs[sent], sent[4:0]);
            else drive_idle(d);
            set_ready(d, stall_left == 0);
            #1;
            if (stall_left > 0) begin
                tests++;
                if (get_ir(d) !== 1'b0) begin
                    failed++;
                    $display("FAIL b2b_stall_in_ready(d%0d): got %b, want 0", d, get_ir(d));
                end
                tests++;
                if (stall_left == 3) begin
                    snap_res = get_res(d);
                    snap_tag = get_tag(d);
                    if (get_ov(d) !== 1'b1 || snap_res !== expv[got] || snap_tag !== got[4:0]) begin
                        failed++;
                        $display("FAIL b2b_stall_head(d%0d): got v=%b res=%h tag=%0d, want v=1 res=%h tag=%0d",
                                 d, get_ov(d), snap_res, snap_tag, expv[got], got);
                    end
                end else if (get_ov(d) !== 1'b1 || get_res(d) !== snap_res || get_tag(d) !== snap_tag) begin
                    failed++;
                    $display("FAIL b2b_stall_hold(d%0d): got v=%b res=%h tag=%0d, want v=1 res=%h tag=%0d",
                             d, get_ov(d), get_res(d), get_tag(d), snap_res, snap_tag);
                end
                stall_left--;
            end else if (get_ov(d) === 1'b1) begin
                tests++;
                if (get_res(d) !== expv[got] || get_tag(d) !== got[4:0]) begin
                    failed++;
                    $display("FAIL b2b_beat(d%0d,%0d): got res=%h tag=%0d, want res=%h tag=%0d",
                             d, got, get_res(d), get_tag(d), expv[got], got);
                end
                got++;
                if (got == 3 && !stall_started) begin
                    stall_started = 1;
                    stall_left = 3;
                end
            end
            if (sent < 8 && get_ir(d) === 1'b1) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        drive_idle(d);
        set_ready(d, 1'b1);
        tests++;
        if (got != 8) begin
            failed++;
            $display("FAIL b2b_count(d%0d): got %0d beats, want 8", d, got);
        end
    endtask

    // Three beats in flight on A (the first parked at the output); reset must wipe them all.
    task automatic test_reset_midflight();
        int n;
        bit leaked;
        set_ready(0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1, 2'b00, 5'd1, 32'h00000100 + i, 5'(i + 1));
            @(posedge clk);
            #1;
        end
        drive_idle(0);
        n = 0;
        while (ia.out_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests++;
        if (ia.out_valid !== 1'b1) begin
            failed++;
            $display("FAIL rstmid_pre_valid: got %b, want 1", ia.out_valid);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (ia.out_valid !== 1'b0 || ia.out_result !== 32'h0 || ia.out_tag !== 5'h0) begin
            failed++;
            $display("FAIL rstmid_async: got v=%b res=%h tag=%h, want 0", ia.out_valid, ia.out_result, ia.out_tag);
        end
        @(posedge clk);
        #3 rst = 1'b0;
        set_ready(0, 1'b1);
        leaked = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (ia.out_valid !== 1'b0) leaked = 1;
        end
        tests++;
        if (leaked) begin
            failed++;
            $display("FAIL rstmid_leak: got out_valid=1 after reset, want 0");
        end
        run_one(0, 5, 2'b01, 5'd4, 32'h80000000, 5'd30, 32'hF8000000, "rstmid_after");
    endtask

    initial begin
        drive_idle(0);
        drive_idle(1);
        drive_idle(2);
        set_ready(0, 1'b1);
        set_ready(1, 1'b1);
        set_ready(2, 1'b1);
        #1;
        test_reset();
        test_ops_a();
        test_ops_b();
        test_ops_c();
        test_back_to_back(0, 32);
        test_back_to_back(1, 32);
        test_back_to_back(2, 8);
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
